// File: rtl/t_block_sequencer.sv
// Drives one shared t_block across every arm joint in turn and streams each
// captured 4x4 DH transform to the downstream chain multiplier over valid/ready.
module t_block_sequencer #(
  parameter int NUM_JOINTS = 6,
  parameter int WIDTH      = 36,
  parameter int T_CYCLES   = 40
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [NUM_JOINTS*WIDTH-1:0] joint_a,
  input  logic [NUM_JOINTS*WIDTH-1:0] joint_d,
  input  logic [NUM_JOINTS*WIDTH-1:0] joint_alpha,
  input  logic [NUM_JOINTS*WIDTH-1:0] joint_theta,
  output logic                        busy,
  output logic                        done,
  output logic                        tb_en,
  output logic                        tb_rst,
  output logic [7:0]                  tb_count,
  output logic [WIDTH-1:0]            tb_a,
  output logic [WIDTH-1:0]            tb_d,
  output logic [WIDTH-1:0]            tb_alpha,
  output logic [WIDTH-1:0]            tb_theta,
  input  logic [16*WIDTH-1:0]         tb_t_matrix,
  output logic                        mat_valid,
  input  logic                        mat_ready,
  output logic [2:0]                  mat_joint,
  output logic [16*WIDTH-1:0]         mat_data
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, OUT, DONE} state_t;

  localparam logic [2:0] LAST_J = 3'(NUM_JOINTS - 1);
  localparam logic [7:0] LAST_C = 8'(T_CYCLES - 1);

  state_t state, state_nx;

  logic [NUM_JOINTS*WIDTH-1:0] tab_a, tab_d, tab_alpha, tab_theta;
  logic [2:0]                  j;
  logic [2:0]                  j_nx;
  logic [7:0]                  cnt;
  logic                        accept;

  assign j_nx   = j + 3'd1;
  assign accept = (state == OUT) && mat_ready && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CLEAR;
      CLEAR:   state_nx = RUN;
      RUN:     if (cnt == LAST_C) state_nx = CAPTURE;
      CAPTURE: state_nx = OUT;
      OUT:     if (mat_ready) state_nx = (j == LAST_J) ? DONE : CLEAR;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // abort outranks a same-cycle acceptance
    if (abort && state != IDLE) state_nx = IDLE;
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    tb_rst    = (state == CLEAR);
    tb_en     = (state == RUN);
    mat_valid = (state == OUT);
    tb_count  = cnt;
    mat_joint = j;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tab_a     <= '0;
      tab_d     <= '0;
      tab_alpha <= '0;
      tab_theta <= '0;
      j         <= '0;
      cnt       <= '0;
      tb_a      <= '0;
      tb_d      <= '0;
      tb_alpha  <= '0;
      tb_theta  <= '0;
      mat_data  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          tab_a     <= joint_a;
          tab_d     <= joint_d;
          tab_alpha <= joint_alpha;
          tab_theta <= joint_theta;
          j         <= '0;
          cnt       <= '0;
          tb_a      <= joint_a[WIDTH-1:0];
          tb_d      <= joint_d[WIDTH-1:0];
          tb_alpha  <= joint_alpha[WIDTH-1:0];
          tb_theta  <= joint_theta[WIDTH-1:0];
        end
        RUN:     if (cnt != LAST_C) cnt <= cnt + 8'd1;
        CAPTURE: mat_data <= tb_t_matrix;
        OUT: if (accept && j != LAST_J) begin
          j        <= j_nx;
          cnt      <= '0;
          tb_a     <= tab_a[j_nx*WIDTH +: WIDTH];
          tb_d     <= tab_d[j_nx*WIDTH +: WIDTH];
          tb_alpha <= tab_alpha[j_nx*WIDTH +: WIDTH];
          tb_theta <= tab_theta[j_nx*WIDTH +: WIDTH];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_t_block_sequencer.sv
// Scoreboard bench for t_block_sequencer with a counting t_block stub, plus a
// second single-joint, single-cycle instance for the minimal configuration.
module tb_t_block_sequencer;

  localparam int NJ = 6;
  localparam int W  = 36;
  localparam int TC = 40;
  localparam int MW = 16 * W;

  logic clk = 1'b0;
  logic rst, start, abort, mat_ready;
  logic [NJ*W-1:0] ja, jd, jal, jth;
  logic busy, done, tb_en, tb_rst, mat_valid;
  logic [7:0] tb_count;
  logic [W-1:0] tb_a, tb_d, tb_alpha, tb_theta;
  logic [MW-1:0] tb_t_matrix, mat_data;
  logic [2:0] mat_joint;

  logic s_start, s_abort, s_mat_ready;
  logic [W-1:0] s_ja, s_jd, s_jal, s_jth;
  logic s_busy, s_done, s_tb_en, s_tb_rst, s_mat_valid;
  logic [7:0] s_tb_count;
  logic [W-1:0] s_tb_a, s_tb_d, s_tb_alpha, s_tb_theta;
  logic [MW-1:0] s_tb_t_matrix, s_mat_data;
  logic [2:0] s_mat_joint;

  always #5 clk = ~clk;

  t_block_sequencer #(.NUM_JOINTS(NJ), .WIDTH(W), .T_CYCLES(TC)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .joint_a(ja), .joint_d(jd), .joint_alpha(jal), .joint_theta(jth),
    .busy(busy), .done(done), .tb_en(tb_en), .tb_rst(tb_rst), .tb_count(tb_count),
    .tb_a(tb_a), .tb_d(tb_d), .tb_alpha(tb_alpha), .tb_theta(tb_theta),
    .tb_t_matrix(tb_t_matrix), .mat_valid(mat_valid), .mat_ready(mat_ready),
    .mat_joint(mat_joint), .mat_data(mat_data)
  );

  t_block_sequencer #(.NUM_JOINTS(1), .WIDTH(W), .T_CYCLES(1)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
    .joint_a(s_ja), .joint_d(s_jd), .joint_alpha(s_jal), .joint_theta(s_jth),
    .busy(s_busy), .done(s_done), .tb_en(s_tb_en), .tb_rst(s_tb_rst), .tb_count(s_tb_count),
    .tb_a(s_tb_a), .tb_d(s_tb_d), .tb_alpha(s_tb_alpha), .tb_theta(s_tb_theta),
    .tb_t_matrix(s_tb_t_matrix), .mat_valid(s_mat_valid), .mat_ready(s_mat_ready),
    .mat_joint(s_mat_joint), .mat_data(s_mat_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] pattern(input int jj);
    logic [MW-1:0] m;
    for (int i = 0; i < 16; i++) m[i*W +: W] = W'(32'h100 * jj + i);
    return m;
  endfunction

  // t_block stub: result is only meaningful after exactly TC enabled cycles
  logic [7:0] en_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst)         en_cnt <= '0;
    else if (tb_rst) en_cnt <= '0;
    else if (tb_en)  en_cnt <= en_cnt + 8'd1;
  end
  always_comb tb_t_matrix = (en_cnt == 8'(TC)) ? pattern(int'(tb_a) - 1) : '1;

  typedef struct { logic [2:0] joint; logic [MW-1:0] data; } exp_t;
  exp_t sb[$];

  task automatic load_tables(input logic [W-1:0] off);
    for (int jj = 0; jj < NJ; jj++) begin
      ja[jj*W +: W]  = W'(jj + 1) + off;
      jd[jj*W +: W]  = W'('h10 + jj) + off;
      jal[jj*W +: W] = W'('h20 + jj) + off;
      jth[jj*W +: W] = W'('h30 + jj) + off;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int jj = 0; jj < NJ; jj++) begin
      e.joint = 3'(jj);
      e.data  = pattern(jj);
      sb.push_back(e);
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge, once inputs have settled
  logic          prev_hold = 1'b0;
  logic [MW-1:0] prev_data;
  logic [2:0]    prev_joint;
  int            exp_cnt = 0;
  int            done_seen = 0;
  always begin
    exp_t e;
    logic [W-1:0] jw;
    @(negedge clk); #1;
    if (rst) prev_hold = 1'b0;
    else begin
      if (prev_hold) begin
        check("hold_data", mat_data, prev_data);
        check("hold_joint", mat_joint, prev_joint);
      end
      prev_hold  = mat_valid && !mat_ready && !abort;
      prev_data  = mat_data;
      prev_joint = mat_joint;
      if (mat_valid) check("no_en_in_out", tb_en, 0);
      if (tb_rst) exp_cnt = 0;
      if (tb_en) begin
        check("tb_count", tb_count, exp_cnt);
        exp_cnt++;
      end
      if (mat_valid && mat_ready && !abort) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e  = sb.pop_front();
          jw = W'(e.joint);
          check("mat_joint", mat_joint, e.joint);
          check("mat_data", mat_data, e.data);
          check("tb_a", tb_a, jw + W'(1));
          check("tb_d", tb_d, jw + W'('h10));
          check("tb_alpha", tb_alpha, jw + W'('h20));
          check("tb_theta", tb_theta, jw + W'('h30));
        end
      end
      if (done) done_seen++;
    end
  end

  logic stall_en = 1'b0, stalled = 1'b0;
  int   stall_left = 0;
  always @(negedge clk) begin
    if (stall_en && !stalled && mat_valid && mat_joint == 3'd2) begin
      mat_ready  = 1'b0;
      stall_left = 5;
      stalled    = 1'b1;
    end else if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) mat_ready = 1'b1;
    end
  end

  task automatic run_seq(input string tag, input int exp_done, input int restart_at);
    int n;
    int d0;
    d0 = done_seen;
    @(negedge clk);
    start = 1'b1;
    push_expected();
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check({tag, "_busy_rise"}, busy, 1);
    while (!done && n < 2000) begin
      if (n == restart_at) begin
        load_tables(W'('h77));
        start = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_done_lat"}, n, exp_done);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_fall"}, busy, 0);
    #2;
    check({tag, "_done_count"}, done_seen - d0, 1);
    check({tag, "_sb_drained"}, sb.size(), 0);
  endtask

  logic [4:0] sm_exp [6] = '{5'b10001, 5'b01001, 5'b00001, 5'b00101, 5'b00011, 5'b00000};

  initial begin
    int n;
    int d0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mat_ready = 1'b1;
    s_start = 1'b0; s_abort = 1'b0; s_mat_ready = 1'b1;
    s_ja = W'('h0AA); s_jd = W'('h0BB); s_jal = W'('h0CC); s_jth = W'('h0DD);
    s_tb_t_matrix = pattern(5);
    load_tables('0);
    #12;
    check("rst_busy", busy, 0);
    check("rst_outs", {done, tb_en, tb_rst, mat_valid, mat_joint, tb_count}, 0);
    check("rst_params", {tb_a, tb_d, tb_alpha, tb_theta}, 0);
    check("rst_mat_data", mat_data, 0);
    @(negedge clk);
    rst = 1'b0;

    run_seq("basic", 259, -1);

    stall_en = 1'b1;
    run_seq("stall", 264, -1);
    stall_en = 1'b0;
    check("stall_seen", stalled, 1);

    run_seq("restart", 259, 100);
    load_tables('0);

    // abort in joint 1 RUN, then a fresh sequence
    d0 = done_seen;
    @(negedge clk);
    start = 1'b1;
    push_expected();
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_in_run", tb_en, 1);
    check("abort_joint1", tb_a, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_outs", {tb_en, tb_rst, mat_valid, done}, 0);
    sb.delete();
    repeat (10) @(negedge clk);
    check("abort_no_done", done_seen - d0, 0);
    run_seq("after_abort", 259, -1);

    // asynchronous reset between edges, mid-RUN
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_outs", {done, tb_en, tb_rst, mat_valid, mat_joint, tb_count}, 0);
    check("arst_params", {tb_a, tb_d, tb_alpha, tb_theta}, 0);
    check("arst_mat_data", mat_data, 0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();

    // single joint, single RUN cycle
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      check($sformatf("small_c%0d", i), {s_tb_rst, s_tb_en, s_mat_valid, s_done, s_busy}, sm_exp[i-1]);
      if (i == 2) check("small_count", s_tb_count, 0);
      if (i == 4) begin
        check("small_data", s_mat_data, pattern(5));
        check("small_joint", s_mat_joint, 0);
        check("small_params", {s_tb_a, s_tb_d, s_tb_alpha, s_tb_theta},
              {W'('h0AA), W'('h0BB), W'('h0CC), W'('h0DD)});
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
